ram_256x64: RTL and testbench

Single-port synchronous static RAM, 256 words × 64 bits, with chip-enable and write-enable controls. It serves as the local data store for the datapath: one read or one write per clock, and registered read data. All state is cleared by a synchronous active-low reset.

---
 rtl/ram_256x64.sv | 73 +++++++
 tb/tb_ram_256x64.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_256x64.sv
// ram_256x64: single-port synchronous RAM, DEPTH words x DATA_WIDTH bits.
// One read or one write per clock. Read data is registered, so it appears
// one cycle after the address is sampled. A synchronous active-low reset
// clears every word and the read register.
//
// Ports:
//   clk    - clock; all state changes on the rising edge
//   rst_n  - synchronous reset, active-low; overrides cen/wen
//   cen    - chip enable, active-high; 0 = idle (no change anywhere)
//   wen    - write enable, active-high; 1 = write, 0 = read (while cen=1)
//   s_addr - word address
//   s_din  - write data
//   s_dout - registered read data; holds between reads
module ram_256x64 #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cen,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] s_addr,
    input  logic [DATA_WIDTH-1:0] s_din,
    output logic [DATA_WIDTH-1:0] s_dout
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] dout_q;
    logic [DATA_WIDTH-1:0] dout_d;

    logic do_write;
    logic do_read;

    assign do_write = cen &  wen;
    assign do_read  = cen & ~wen;

    // Next-state of the array: only the addressed word can change.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (do_write) begin
            mem_d[s_addr] = s_din;
        end
    end

    // Read register: reads the pre-write array, writes leave it untouched.
    always_comb begin
        dout_d = dout_q;
        if (do_read) begin
            dout_d = mem_q[s_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            dout_q <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            dout_q <= dout_d;
        end
    end

    assign s_dout = dout_q;

endmodule

// File: tb/tb_ram_256x64.sv
module tb_ram_256x64;

    localparam int DW = 64;
    localparam int AW = 8;
    localparam int DEPTH = 256;

    logic          clk;
    logic          rst_n;
    logic          cen;
    logic          wen;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_din;
    logic [DW-1:0] s_dout;

    int vectors;
    int miscompares;

    typedef struct {
        logic          rst_n;
        logic          cen;
        logic          wen;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
    } vec_t;

    // Scoreboard: expected s_dout after each edge, pushed as stimulus is driven.
    logic [DW-1:0] sb [$];

    // Reference model state.
    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] model_dout;

    ram_256x64 #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cen   (cen),
        .wen   (wen),
        .s_addr(s_addr),
        .s_din (s_din),
        .s_dout(s_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one vector, advance the model, and queue the expected output.
    task automatic apply(input vec_t v);
        rst_n  = v.rst_n;
        cen    = v.cen;
        wen    = v.wen;
        s_addr = v.addr;
        s_din  = v.din;
        if (!v.rst_n) begin
            for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
            model_dout = '0;
        end else if (v.cen && v.wen) begin
            model_mem[v.addr] = v.din;
        end else if (v.cen && !v.wen) begin
            model_dout = model_mem[v.addr];
        end
        sb.push_back(model_dout);
    endtask

    function automatic vec_t mk(input logic r, input logic c, input logic w,
                                input logic [AW-1:0] a, input logic [DW-1:0] d);
        vec_t v;
        v.rst_n = r; v.cen = c; v.wen = w; v.addr = a; v.din = d;
        return v;
    endfunction

    task automatic test_reset();
        vec_t q [$];
        logic [DW-1:0] exp;
        q.push_back(mk(0, 1, 0, 8'h00, '0));
        q.push_back(mk(0, 1, 1, 8'h00, '1));
        q.push_back(mk(1, 1, 0, 8'h00, '0));
        q.push_back(mk(1, 1, 0, 8'h7F, '0));
        q.push_back(mk(1, 1, 0, 8'hFF, '0));
        foreach (q[i]) begin
            apply(q[i]);
            @(posedge clk); #1;
            exp = sb.pop_front();
            vectors++;
            if (s_dout !== exp || s_dout !== 64'h0) begin
                miscompares++;
                $display("FAIL reset[%0d] s_dout=%h expected %h", i, s_dout, exp);
            end
        end
    endtask

    task automatic test_write_read();
        vec_t q [$];
        logic [DW-1:0] exp;
        logic [DW-1:0] lit [6];
        lit = '{64'h0, 64'h0, 64'h0,
                64'h1111_2222_EEEE_FFFF, 64'h1234_2345_3456_4567, 64'hAAAA_BBBB_CCCC_DDDD};
        q.push_back(mk(1, 1, 1, 8'h00, 64'h1111_2222_EEEE_FFFF));
        q.push_back(mk(1, 1, 1, 8'h02, 64'h1234_2345_3456_4567));
        q.push_back(mk(1, 1, 1, 8'h05, 64'hAAAA_BBBB_CCCC_DDDD));
        q.push_back(mk(1, 1, 0, 8'h00, '0));
        q.push_back(mk(1, 1, 0, 8'h02, '0));
        q.push_back(mk(1, 1, 0, 8'h05, '0));
        foreach (q[i]) begin
            apply(q[i]);
            @(posedge clk); #1;
            exp = sb.pop_front();
            vectors++;
            if (s_dout !== exp || s_dout !== lit[i]) begin
                miscompares++;
                $display("FAIL write_read[%0d] s_dout=%h expected %h", i, s_dout, lit[i]);
            end
        end
    endtask

    task automatic test_cen_blocks_write();
        vec_t q [$];
        logic [DW-1:0] exp;
        // Start from a known zero output by reading an unwritten word.
        q.push_back(mk(1, 1, 0, 8'h40, '0));
        q.push_back(mk(1, 0, 1, 8'h10, 64'h0000_1111_FFFF_AAAA));
        q.push_back(mk(1, 0, 1, 8'h10, 64'h0000_1111_FFFF_AAAA));
        q.push_back(mk(1, 0, 0, 8'h05, 64'h0000_1111_FFFF_AAAA));
        q.push_back(mk(1, 1, 0, 8'h10, '0));
        foreach (q[i]) begin
            apply(q[i]);
            @(posedge clk); #1;
            exp = sb.pop_front();
            vectors++;
            if (s_dout !== exp || s_dout !== 64'h0) begin
                miscompares++;
                $display("FAIL cen_blocks_write[%0d] s_dout=%h expected %h", i, s_dout, exp);
            end
        end
    endtask

    task automatic test_hold();
        vec_t q [$];
        logic [DW-1:0] exp;
        q.push_back(mk(1, 1, 0, 8'h05, '0));
        q.push_back(mk(1, 0, 0, 8'h00, '0));
        q.push_back(mk(1, 0, 1, 8'h02, 64'h1));
        q.push_back(mk(1, 0, 0, 8'hFF, '1));
        foreach (q[i]) begin
            apply(q[i]);
            @(posedge clk); #1;
            exp = sb.pop_front();
            vectors++;
            if (s_dout !== exp || s_dout !== 64'hAAAA_BBBB_CCCC_DDDD) begin
                miscompares++;
                $display("FAIL hold[%0d] s_dout=%h expected %h", i, s_dout, exp);
            end
        end
    endtask

    task automatic test_overwrite();
        vec_t q [$];
        logic [DW-1:0] exp;
        logic [DW-1:0] lit [5];
        lit = '{64'hAAAA_BBBB_CCCC_DDDD, 64'hAAAA_BBBB_CCCC_DDDD,
                64'hDEAD_BEEF_0123_4567, 64'h5A5A_5A5A_A5A5_A5A5, 64'h1234_2345_3456_4567};
        q.push_back(mk(1, 1, 1, 8'hFF, 64'hDEAD_BEEF_0123_4567));
        q.push_back(mk(1, 1, 1, 8'h00, 64'h5A5A_5A5A_A5A5_A5A5));
        q.push_back(mk(1, 1, 0, 8'hFF, '0));
        q.push_back(mk(1, 1, 0, 8'h00, '0));
        q.push_back(mk(1, 1, 0, 8'h02, '0));
        foreach (q[i]) begin
            apply(q[i]);
            @(posedge clk); #1;
            exp = sb.pop_front();
            vectors++;
            if (s_dout !== exp || s_dout !== lit[i]) begin
                miscompares++;
                $display("FAIL overwrite[%0d] s_dout=%h expected %h", i, s_dout, lit[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        vec_t q [$];
        logic [DW-1:0] exp;
        q.push_back(mk(0, 1, 1, 8'h03, 64'hFFFF_FFFF_FFFF_FFFF));
        q.push_back(mk(1, 1, 0, 8'h03, '0));
        q.push_back(mk(1, 1, 0, 8'h00, '0));
        q.push_back(mk(1, 1, 0, 8'hFF, '0));
        foreach (q[i]) begin
            apply(q[i]);
            @(posedge clk); #1;
            exp = sb.pop_front();
            vectors++;
            if (s_dout !== exp || s_dout !== 64'h0) begin
                miscompares++;
                $display("FAIL reset_mid[%0d] s_dout=%h expected %h", i, s_dout, exp);
            end
        end
    endtask

    // Random mix of reads, writes and idles over a small address window so
    // write-then-read of the same address happens often.
    task automatic test_back_to_back();
        logic [DW-1:0] exp;
        vec_t v;
        for (int i = 0; i < 400; i++) begin
            v = mk(($urandom_range(0, 63) != 0), ($urandom_range(0, 4) != 0),
                   ($urandom_range(0, 1) == 1),
                   (i % 2 == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(248, 255)),
                   {$urandom, $urandom});
            apply(v);
            @(posedge clk); #1;
            exp = sb.pop_front();
            vectors++;
            if (s_dout !== exp) begin
                miscompares++;
                $display("FAIL back_to_back[%0d] s_dout=%h expected %h", i, s_dout, exp);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n  = 1'b1;
        cen    = 1'b0;
        wen    = 1'b0;
        s_addr = '0;
        s_din  = '0;
        model_dout = '0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        @(posedge clk); #1;

        test_reset();
        test_write_read();
        test_cen_blocks_write();
        test_hold();
        test_overwrite();
        test_reset_mid();
        test_back_to_back();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
